// File: rtl/gps_log_pkg.sv
// Shared definitions for the GPS IQ capture path.
//   cap_state_e     : capture controller states
//   LOG_DEPTH       : words in the downstream IQ log buffer
//   LOG_WORD_W      : width of one log buffer word
//   pairs_per_word  : number of {I,Q} pairs packed into one log word
package gps_log_pkg;

   localparam int LOG_DEPTH  = 1024;
   localparam int LOG_WORD_W = 16;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_TRIG = 2'd1,
      CAPTURE   = 2'd2,
      DONE      = 2'd3
   } cap_state_e;

   function automatic int pairs_per_word(input int samp_w);
      return LOG_WORD_W / (2 * samp_w);
   endfunction

endpackage

// File: rtl/gps_iq_pack.sv
// Packs kept {I,Q} sample pairs MSB-first into log words.
//   clk, rst     : clock, synchronous active-low reset
//   clear_i      : drop any partial word and restart at the first slot
//   load_i       : pair_i is a kept pair this cycle
//   pair_i       : {samp_i, samp_q}
//   word_rdy_o   : this load completes a word (combinational)
//   word_o       : completed word, valid together with word_rdy_o
module gps_iq_pack
   import gps_log_pkg::*;
#(
   parameter int SAMP_W = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear_i,
   input  logic                    load_i,
   input  logic [2*SAMP_W-1:0]     pair_i,
   output logic                    word_rdy_o,
   output logic [LOG_WORD_W-1:0]   word_o
);

   localparam int PAIR_W = 2 * SAMP_W;
   localparam int PPW    = pairs_per_word(SAMP_W);
   localparam int CNT_W  = (PPW > 1) ? $clog2(PPW) : 1;

   // Only the low bits need storing: the incoming pair is appended
   // combinationally, so the final pair never waits a cycle.
   logic [LOG_WORD_W-PAIR_W-1:0] sr_q, sr_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;

   assign word_o     = {sr_q, pair_i};
   assign word_rdy_o = load_i && (cnt_q == CNT_W'(PPW - 1));

   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      if (clear_i) begin
         sr_d  = '0;
         cnt_d = '0;
      end else if (load_i) begin
         sr_d  = word_o[LOG_WORD_W-PAIR_W-1:0];
         cnt_d = word_rdy_o ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/gps_iq_capture.sv
// GPS IQ capture front end: arm, optional epoch trigger, decimation,
// packing and a bounded run of write strobes into the IQ log buffer.
//   clk, rst            : clock, synchronous active-low reset
//   arm, abort, trig    : host start, host abort, code-epoch pulse
//   samp_vld/i/q        : raw sampler pairs
//   decim, nwords       : keep ratio and word count, latched at arm
//   log_wr, log_data    : one-cycle write strobe and packed word
//   busy, done          : WAIT_TRIG|CAPTURE, DONE
//   word_cnt            : words written since the last arm
//
// state     | meaning
// IDLE      | waiting for arm
// WAIT_TRIG | armed, waiting for the code epoch
// CAPTURE   | decimating and packing, writing words
// DONE      | record complete, extra samples ignored
module gps_iq_capture
   import gps_log_pkg::*;
#(
   parameter int SAMP_W    = 2,
   parameter int DECIM_W   = 8,
   parameter int LOG_DEPTH = gps_log_pkg::LOG_DEPTH,
   parameter int TRIG_EN   = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    arm,
   input  logic                    abort,
   input  logic                    trig,
   input  logic                    samp_vld,
   input  logic [SAMP_W-1:0]       samp_i,
   input  logic [SAMP_W-1:0]       samp_q,
   input  logic [DECIM_W-1:0]      decim,
   input  logic [10:0]             nwords,
   output logic                    log_wr,
   output logic [LOG_WORD_W-1:0]   log_data,
   output logic                    busy,
   output logic                    done,
   output logic [10:0]             word_cnt
);

   localparam int WCNT_W = 11;

   cap_state_e                state_q, state_d;
   logic [DECIM_W-1:0]        decim_q, decim_d;
   logic [DECIM_W-1:0]        dcnt_q, dcnt_d;
   logic [WCNT_W-1:0]         target_q, target_d;
   logic [WCNT_W-1:0]         wcnt_q, wcnt_d;
   logic                      log_wr_q, log_wr_d;
   logic [LOG_WORD_W-1:0]     log_data_q, log_data_d;
   logic [WCNT_W-1:0]         nwords_clamped;

   logic                      sampling;
   logic                      start;
   logic                      pack_clear;
   logic                      pack_load;
   logic                      word_rdy;
   logic [LOG_WORD_W-1:0]     pack_word;

   assign start = !abort && (state_q == IDLE || state_q == DONE) && arm;

   // The trig cycle itself already samples, so its pair can be the first.
   assign sampling = !abort &&
                     (state_q == CAPTURE || (state_q == WAIT_TRIG && trig));

   assign pack_clear = abort || start;
   assign pack_load  = sampling && samp_vld && (dcnt_q == '0);

   assign nwords_clamped = (nwords == '0 || nwords > WCNT_W'(LOG_DEPTH)) ?
                           WCNT_W'(LOG_DEPTH) : nwords;

   gps_iq_pack #(
      .SAMP_W (SAMP_W)
   ) u_pack (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (pack_clear),
      .load_i     (pack_load),
      .pair_i     ({samp_i, samp_q}),
      .word_rdy_o (word_rdy),
      .word_o     (pack_word)
   );

   always_comb begin
      state_d    = state_q;
      decim_d    = decim_q;
      target_d   = target_q;
      dcnt_d     = dcnt_q;
      wcnt_d     = wcnt_q;
      log_wr_d   = 1'b0;
      log_data_d = log_data_q;

      if (abort) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE, DONE: begin
               if (arm) begin
                  state_d  = (TRIG_EN != 0) ? WAIT_TRIG : CAPTURE;
                  decim_d  = decim;
                  target_d = nwords_clamped;
                  dcnt_d   = '0;
                  wcnt_d   = '0;
               end
            end
            WAIT_TRIG: begin
               if (trig) state_d = CAPTURE;
            end
            CAPTURE: ;
            default: state_d = IDLE;
         endcase

         if (sampling && samp_vld)
            dcnt_d = (dcnt_q == decim_q) ? '0 : dcnt_q + 1'b1;

         if (word_rdy) begin
            log_wr_d   = 1'b1;
            log_data_d = pack_word;
            wcnt_d     = wcnt_q + 1'b1;
            if (wcnt_d == target_q) state_d = DONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         decim_q    <= '0;
         dcnt_q     <= '0;
         target_q   <= '0;
         wcnt_q     <= '0;
         log_wr_q   <= 1'b0;
         log_data_q <= '0;
      end else begin
         decim_q    <= decim_d;
         dcnt_q     <= dcnt_d;
         target_q   <= target_d;
         wcnt_q     <= wcnt_d;
         log_wr_q   <= log_wr_d;
         log_data_q <= log_data_d;
      end
   end

   assign log_wr   = log_wr_q;
   assign log_data = log_data_q;
   assign busy     = (state_q == WAIT_TRIG) || (state_q == CAPTURE);
   assign done     = (state_q == DONE);
   assign word_cnt = wcnt_q;

endmodule

// File: tb/tb_gps_iq_capture.sv
module tb_gps_iq_capture;

   localparam int SAMP_W  = 2;
   localparam int DECIM_W = 8;
   localparam int PAIR_W  = 2 * SAMP_W;
   localparam int PPW     = 16 / PAIR_W;
   localparam int DEPTH   = 1024;
   localparam int TRIG_EN = 1;

   logic                clk = 1'b0;
   logic                rst, arm, abort, trig, samp_vld;
   logic [SAMP_W-1:0]   samp_i, samp_q;
   logic [DECIM_W-1:0]  decim;
   logic [10:0]         nwords;
   logic                log_wr, busy, done;
   logic [15:0]         log_data;
   logic [10:0]         word_cnt;

   always #5 clk = ~clk;

   gps_iq_capture #(
      .SAMP_W    (SAMP_W),
      .DECIM_W   (DECIM_W),
      .LOG_DEPTH (DEPTH),
      .TRIG_EN   (TRIG_EN)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .arm      (arm),
      .abort    (abort),
      .trig     (trig),
      .samp_vld (samp_vld),
      .samp_i   (samp_i),
      .samp_q   (samp_q),
      .decim    (decim),
      .nwords   (nwords),
      .log_wr   (log_wr),
      .log_data (log_data),
      .busy     (busy),
      .done     (done),
      .word_cnt (word_cnt)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Reference model: phase 0 idle, 1 waiting for epoch, 2 capturing, 3 done.
   // Kept samples are those whose index since capture start is a multiple
   // of decim+1; pairs collect in a queue until a word's worth is present.
   int          m_phase, m_decim, m_target, m_vidx, m_wcnt;
   bit          m_wr;
   logic [15:0] m_data;
   int          m_pairs[$];

   int          n_wr;
   logic [15:0] wr_q[$];

   task automatic model_take();
      logic [15:0] w;
      if (!samp_vld) return;
      if (m_vidx % (m_decim + 1) == 0) m_pairs.push_back(int'({samp_i, samp_q}));
      m_vidx++;
      if (m_pairs.size() == PPW) begin
         w = '0;
         foreach (m_pairs[k]) w = (w << PAIR_W) | 16'(m_pairs[k]);
         m_pairs.delete();
         m_wr   = 1'b1;
         m_data = w;
         m_wcnt++;
         if (m_wcnt == m_target) m_phase = 3;
      end
   endtask

   task automatic model_edge();
      if (!rst) begin
         m_phase = 0; m_wcnt = 0; m_wr = 1'b0; m_data = '0;
         m_vidx = 0; m_pairs.delete();
         return;
      end
      m_wr = 1'b0;
      if (abort) begin
         m_phase = 0;
         m_pairs.delete();
         return;
      end
      case (m_phase)
         0, 3: if (arm) begin
            m_phase  = (TRIG_EN != 0) ? 1 : 2;
            m_decim  = int'(decim);
            m_target = (nwords == 0 || int'(nwords) > DEPTH) ? DEPTH : int'(nwords);
            m_wcnt   = 0;
            m_vidx   = 0;
            m_pairs.delete();
         end
         1: if (trig) begin
            m_phase = 2;
            model_take();
         end
         2: model_take();
         default: ;
      endcase
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      chk("log_wr",   32'(log_wr),   32'(m_wr));
      chk("log_data", 32'(log_data), 32'(m_data));
      chk("busy",     32'(busy),     32'(m_phase == 1 || m_phase == 2));
      chk("done",     32'(done),     32'(m_phase == 3));
      chk("word_cnt", 32'(word_cnt), 32'(m_wcnt));
      if (log_wr) begin
         n_wr++;
         wr_q.push_back(log_data);
      end
      arm   = 1'b0;
      abort = 1'b0;
      trig  = 1'b0;
   endtask

   task automatic do_arm(input int d, input int n);
      decim  = DECIM_W'(d);
      nwords = 11'(n);
      arm    = 1'b1;
      samp_vld = 1'b0;
      tick();
   endtask

   task automatic feed(input logic [PAIR_W-1:0] p);
      samp_vld = 1'b1;
      {samp_i, samp_q} = p;
      tick();
   endtask

   task automatic idle_cycles(input int n);
      samp_vld = 1'b0;
      for (int c = 0; c < n; c++) tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_err);
      $fatal(1);
   end

   initial begin
      int base;
      rst = 1'b0; arm = 1'b0; abort = 1'b0; trig = 1'b0; samp_vld = 1'b0;
      samp_i = '0; samp_q = '0; decim = '0; nwords = '0;
      m_decim = 0; m_target = 0;
      n_wr = 0;
      #2;
      idle_cycles(3);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_data", 32'(log_data), 32'd0);
      rst = 1'b1;
      idle_cycles(2);

      // Two words, pairs 1..8, trig coincident with the first sample.
      wr_q.delete();
      do_arm(0, 2);
      trig = 1'b1;
      for (int p = 1; p <= 8; p++) feed(PAIR_W'(p));
      idle_cycles(2);
      chk("tp1_nwr", 32'(wr_q.size()), 32'd2);
      if (wr_q.size() == 2) begin
         chk("tp1_w0", 32'(wr_q[0]), 32'h1234);
         chk("tp1_w1", 32'(wr_q[1]), 32'h5678);
      end
      chk("tp1_done", 32'(done), 32'd1);
      chk("tp1_cnt",  32'(word_cnt), 32'd2);

      // decim=3 keeps samples 0,4,8,C.
      wr_q.delete();
      do_arm(3, 1);
      trig = 1'b1;
      for (int p = 0; p < 16; p++) feed(PAIR_W'(p));
      idle_cycles(2);
      chk("decim_nwr", 32'(wr_q.size()), 32'd1);
      if (wr_q.size() == 1) chk("decim_w", 32'(wr_q[0]), 32'h048C);

      // Full depth: nwords=0, then an over-range count that clamps.
      for (int r = 0; r < 2; r++) begin
         base = n_wr;
         do_arm(0, (r == 0) ? 0 : 1500);
         trig = 1'b1;
         for (int c = 0; c < DEPTH * PPW + 30; c++) feed(PAIR_W'($urandom));
         chk("full_nwr",  32'(n_wr - base), 32'(DEPTH));
         chk("full_done", 32'(done), 32'd1);
         chk("full_cnt",  32'(word_cnt), 32'(DEPTH));
      end

      // Abort coinciding with the completing pair; then a clean re-arm.
      base = n_wr;
      do_arm(0, 4);
      trig = 1'b1;
      for (int p = 1; p <= 3; p++) feed(PAIR_W'(p));
      abort = 1'b1;
      feed(PAIR_W'(4));
      idle_cycles(2);
      chk("abort_nwr",  32'(n_wr - base), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      wr_q.delete();
      do_arm(0, 1);
      trig = 1'b1;
      for (int p = 9; p <= 12; p++) feed(PAIR_W'(p));
      idle_cycles(2);
      chk("rearm_nwr", 32'(wr_q.size()), 32'd1);
      if (wr_q.size() == 1) chk("rearm_w", 32'(wr_q[0]), 32'h9ABC);

      // Armed without an epoch: samples must be ignored.
      base = n_wr;
      do_arm(1, 1);
      for (int c = 0; c < 500; c++) feed(PAIR_W'($urandom));
      chk("notrig_nwr",  32'(n_wr - base), 32'd0);
      chk("notrig_busy", 32'(busy), 32'd1);
      wr_q.delete();
      trig = 1'b1;
      feed(PAIR_W'(4'hA));
      for (int c = 0; c < 2 * (PPW - 1) + 4; c++) feed(PAIR_W'(4'h3));
      chk("trig_nwr", 32'(wr_q.size()), 32'd1);
      if (wr_q.size() == 1) chk("trig_msb", 32'(wr_q[0][15:12]), 32'hA);

      // Reset mid-capture with arm asserted in the same cycle.
      do_arm(0, 4);
      trig = 1'b1;
      for (int c = 0; c < 6; c++) feed(PAIR_W'($urandom));
      rst = 1'b0;
      arm = 1'b1;
      feed(PAIR_W'(1));
      chk("rst_wr",   32'(log_wr), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cnt",  32'(word_cnt), 32'd0);
      chk("rst_data", 32'(log_data), 32'd0);
      rst = 1'b1;
      idle_cycles(2);
      chk("rst_arm_ignored", 32'(busy), 32'd0);

      // Randomised traffic against the model.
      for (int c = 0; c < 6000; c++) begin
         if ($urandom_range(0, 39) == 0) begin
            decim  = DECIM_W'($urandom_range(0, 3));
            nwords = 11'($urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 6));
            arm    = 1'b1;
         end
         abort    = ($urandom_range(0, 299) == 0);
         trig     = ($urandom_range(0, 19) == 0);
         rst      = ($urandom_range(0, 1999) != 0);
         samp_vld = ($urandom_range(0, 3) != 0);
         {samp_i, samp_q} = PAIR_W'($urandom);
         tick();
         rst = 1'b1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
